milestone_sequencer: RTL and testbench

Top-level scheduler for the image decoder. It sequences UART image load, then Milestone 2 (IDCT), then Milestone 1 (colour-space conversion), then hands the SRAM to VGA display. It owns the single SRAM port: a combinational mux forwards the address, write data and write enable of exactly one requester, chosen by a registered owner field. It also measures the runtime of each milestone.

---
 rtl/milestone_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_milestone_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/milestone_sequencer.sv
// Decoder top-level scheduler: UART load -> M2 -> M1 -> VGA, owns the single SRAM port.
// Optional watchdog on UART/RUN states when MILESTONE_SEQ_WATCHDOG_EN is defined.
//
// state      | meaning
// S_IDLE     | waiting for start, SRAM unowned
// S_UART     | image load in progress, UART owns SRAM
// S_M2_START | one-cycle m2_start pulse, M2 owns SRAM
// S_M2_RUN   | waiting for m2_finish, counting cycles
// S_M1_START | one-cycle m1_start pulse, M1 owns SRAM
// S_M1_RUN   | waiting for m1_finish, counting cycles
// S_DONE     | VGA owns SRAM, waiting for next start
// S_ERROR    | watchdog expired, SRAM unowned, waiting for start
module milestone_sequencer #(
    parameter logic        SKIP_M2    = 1'b0,
    parameter logic [31:0] WDOG_LIMIT = 32'd4000000
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic        uart_done,
    output logic        uart_en,
    output logic        m2_start,
    input  logic        m2_finish,
    output logic        m1_start,
    input  logic        m1_finish,
    input  logic [17:0] uart_SRAM_address,
    input  logic [15:0] uart_SRAM_write_data,
    input  logic        uart_SRAM_we_n,
    input  logic [17:0] m2_SRAM_address,
    input  logic [15:0] m2_SRAM_write_data,
    input  logic        m2_SRAM_we_n,
    input  logic [17:0] m1_SRAM_address,
    input  logic [15:0] m1_SRAM_write_data,
    input  logic        m1_SRAM_we_n,
    input  logic [17:0] vga_SRAM_address,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  owner,
    output logic        done,
    output logic        error,
    output logic [31:0] m2_cycles,
    output logic [31:0] m1_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UART,
        S_M2_START,
        S_M2_RUN,
        S_M1_START,
        S_M1_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_UART = 3'd1;
    localparam logic [2:0] OWN_M2   = 3'd2;
    localparam logic [2:0] OWN_M1   = 3'd3;
    localparam logic [2:0] OWN_VGA  = 3'd4;

    state_t      state_q;
    logic [2:0]  owner_q;
    logic        uart_en_q;
    logic        m2_start_q;
    logic        m1_start_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] m2_cycles_q;
    logic [31:0] m1_cycles_q;
    logic        wdog_hit;

`ifdef MILESTONE_SEQ_WATCHDOG_EN
    // Every watched state is entered from an unwatched one, so clearing
    // outside them is the same as clearing on entry.
    logic [31:0] wdog_q;
    logic        watched;

    assign watched = (state_q == S_UART) || (state_q == S_M2_RUN) || (state_q == S_M1_RUN);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            wdog_q <= '0;
        end else if (watched) begin
            wdog_q <= wdog_q + 32'd1;
        end else begin
            wdog_q <= '0;
        end
    end

    assign wdog_hit = watched && (wdog_q == WDOG_LIMIT - 32'd1);
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_LIMIT;
    assign wdog_hit    = 1'b0;
`endif

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            uart_en_q   <= 1'b0;
            m2_start_q  <= 1'b0;
            m1_start_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            m2_cycles_q <= '0;
            m1_cycles_q <= '0;
        end else begin
            m2_start_q <= 1'b0;
            m1_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q   <= S_UART;
                        owner_q   <= OWN_UART;
                        uart_en_q <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                    end
                end
                S_UART: begin
                    if (uart_done) begin
                        uart_en_q <= 1'b0;
                        if (SKIP_M2) begin
                            state_q     <= S_M1_START;
                            owner_q     <= OWN_M1;
                            m1_start_q  <= 1'b1;
                            m1_cycles_q <= '0;
                        end else begin
                            state_q     <= S_M2_START;
                            owner_q     <= OWN_M2;
                            m2_start_q  <= 1'b1;
                            m2_cycles_q <= '0;
                        end
                    end else if (wdog_hit) begin
                        state_q   <= S_ERROR;
                        owner_q   <= OWN_NONE;
                        uart_en_q <= 1'b0;
                        error_q   <= 1'b1;
                    end
                end
                S_M2_START: state_q <= S_M2_RUN;
                S_M2_RUN: begin
                    if (m2_finish) begin
                        state_q     <= S_M1_START;
                        owner_q     <= OWN_M1;
                        m1_start_q  <= 1'b1;
                        m1_cycles_q <= '0;
                    end else if (wdog_hit) begin
                        state_q <= S_ERROR;
                        owner_q <= OWN_NONE;
                        error_q <= 1'b1;
                    end else if (m2_cycles_q != '1) begin
                        m2_cycles_q <= m2_cycles_q + 32'd1;
                    end
                end
                S_M1_START: state_q <= S_M1_RUN;
                S_M1_RUN: begin
                    if (m1_finish) begin
                        state_q <= S_DONE;
                        owner_q <= OWN_VGA;
                        done_q  <= 1'b1;
                    end else if (wdog_hit) begin
                        state_q <= S_ERROR;
                        owner_q <= OWN_NONE;
                        error_q <= 1'b1;
                    end else if (m1_cycles_q != '1) begin
                        m1_cycles_q <= m1_cycles_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Unowned and VGA grants both hold we_n high so a reset never leaks a write.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (owner_q)
            OWN_UART: begin
                SRAM_address    = uart_SRAM_address;
                SRAM_write_data = uart_SRAM_write_data;
                SRAM_we_n       = uart_SRAM_we_n;
            end
            OWN_M2: begin
                SRAM_address    = m2_SRAM_address;
                SRAM_write_data = m2_SRAM_write_data;
                SRAM_we_n       = m2_SRAM_we_n;
            end
            OWN_M1: begin
                SRAM_address    = m1_SRAM_address;
                SRAM_write_data = m1_SRAM_write_data;
                SRAM_we_n       = m1_SRAM_we_n;
            end
            OWN_VGA: SRAM_address = vga_SRAM_address;
            default: ;
        endcase
    end

    assign owner     = owner_q;
    assign uart_en   = uart_en_q;
    assign m2_start  = m2_start_q;
    assign m1_start  = m1_start_q;
    assign done      = done_q;
    assign error     = error_q;
    assign m2_cycles = m2_cycles_q;
    assign m1_cycles = m1_cycles_q;

endmodule

// File: tb/tb_milestone_sequencer.sv
// Self-checking bench for milestone_sequencer: table walk, randomized full sequences,
// SKIP_M2 instance, mid-run reset and (when compiled in) watchdog expiry.
module tb_milestone_sequencer;

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0, uart_done = 1'b0, m2_finish = 1'b0, m1_finish = 1'b0;
    logic        start_b = 1'b0, uart_done_b = 1'b0, m2_finish_b = 1'b0, m1_finish_b = 1'b0;
    logic [17:0] uart_a = '0, m2_a = '0, m1_a = '0, vga_a = '0;
    logic [15:0] uart_d = '0, m2_d = '0, m1_d = '0;
    logic        uart_we = 1'b1, m2_we = 1'b1, m1_we = 1'b1;

    logic        uart_en, m2_start, m1_start, done, error, SRAM_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic [2:0]  owner;
    logic [31:0] m2_cycles, m1_cycles;

    logic        uart_en_b, m2_start_b, m1_start_b, done_b, error_b, we_n_b;
    logic [17:0] addr_b;
    logic [15:0] data_b;
    logic [2:0]  owner_b;
    logic [31:0] m2_cycles_b, m1_cycles_b;

    int tests = 0;
    int fails = 0;
    int m2p = 0, m1p = 0, m2p_b = 0;

    always #5 clk = ~clk;

    milestone_sequencer #(.SKIP_M2(1'b0), .WDOG_LIMIT(32'd1000)) dut (
        .Clock_50(clk), .Resetn(Resetn), .start(start), .uart_done(uart_done),
        .uart_en(uart_en), .m2_start(m2_start), .m2_finish(m2_finish),
        .m1_start(m1_start), .m1_finish(m1_finish),
        .uart_SRAM_address(uart_a), .uart_SRAM_write_data(uart_d), .uart_SRAM_we_n(uart_we),
        .m2_SRAM_address(m2_a), .m2_SRAM_write_data(m2_d), .m2_SRAM_we_n(m2_we),
        .m1_SRAM_address(m1_a), .m1_SRAM_write_data(m1_d), .m1_SRAM_we_n(m1_we),
        .vga_SRAM_address(vga_a),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .owner(owner), .done(done), .error(error), .m2_cycles(m2_cycles), .m1_cycles(m1_cycles)
    );

    milestone_sequencer #(.SKIP_M2(1'b1)) dut_skip (
        .Clock_50(clk), .Resetn(Resetn), .start(start_b), .uart_done(uart_done_b),
        .uart_en(uart_en_b), .m2_start(m2_start_b), .m2_finish(m2_finish_b),
        .m1_start(m1_start_b), .m1_finish(m1_finish_b),
        .uart_SRAM_address(uart_a), .uart_SRAM_write_data(uart_d), .uart_SRAM_we_n(uart_we),
        .m2_SRAM_address(m2_a), .m2_SRAM_write_data(m2_d), .m2_SRAM_we_n(m2_we),
        .m1_SRAM_address(m1_a), .m1_SRAM_write_data(m1_d), .m1_SRAM_we_n(m1_we),
        .vga_SRAM_address(vga_a),
        .SRAM_address(addr_b), .SRAM_write_data(data_b), .SRAM_we_n(we_n_b),
        .owner(owner_b), .done(done_b), .error(error_b), .m2_cycles(m2_cycles_b), .m1_cycles(m1_cycles_b)
    );

`ifdef MILESTONE_SEQ_WATCHDOG_EN
    logic        start_c = 1'b0, uart_done_c = 1'b0;
    logic        uart_en_c, m2_start_c, m1_start_c, done_c, error_c, we_n_c;
    logic [17:0] addr_c;
    logic [15:0] data_c;
    logic [2:0]  owner_c;
    logic [31:0] m2_cycles_c, m1_cycles_c;

    milestone_sequencer #(.SKIP_M2(1'b0), .WDOG_LIMIT(32'd100)) dut_wd (
        .Clock_50(clk), .Resetn(Resetn), .start(start_c), .uart_done(uart_done_c),
        .uart_en(uart_en_c), .m2_start(m2_start_c), .m2_finish(1'b0),
        .m1_start(m1_start_c), .m1_finish(1'b0),
        .uart_SRAM_address(uart_a), .uart_SRAM_write_data(uart_d), .uart_SRAM_we_n(uart_we),
        .m2_SRAM_address(m2_a), .m2_SRAM_write_data(m2_d), .m2_SRAM_we_n(m2_we),
        .m1_SRAM_address(m1_a), .m1_SRAM_write_data(m1_d), .m1_SRAM_we_n(m1_we),
        .vga_SRAM_address(vga_a),
        .SRAM_address(addr_c), .SRAM_write_data(data_c), .SRAM_we_n(we_n_c),
        .owner(owner_c), .done(done_c), .error(error_c), .m2_cycles(m2_cycles_c), .m1_cycles(m1_cycles_c)
    );
`endif

    // Start pulses are counted as observed levels, one sample per cycle.
    always @(negedge clk) begin
        if (m2_start) m2p++;
        if (m1_start) m1p++;
        if (m2_start_b) m2p_b++;
    end

    typedef struct packed {
        logic [2:0]  owner;
        logic        uart_en;
        logic        m2s;
        logic        m1s;
        logic        done;
        logic [31:0] m2c;
        logic [31:0] m1c;
    } exp_t;

    typedef struct {
        logic [3:0] in;   // start, uart_done, m2_finish, m1_finish
        exp_t       exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in, input logic [2:0] own, input logic ue,
                                input logic m2s, input logic m1s, input logic dn,
                                input int m2c, input int m1c);
        vec_t v;
        v.in         = in;
        v.exp.owner  = own;
        v.exp.uart_en = ue;
        v.exp.m2s    = m2s;
        v.exp.m1s    = m1s;
        v.exp.done   = dn;
        v.exp.m2c    = 32'(m2c);
        v.exp.m1c    = 32'(m1c);
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Mux reference: whoever the bench believes owns the port.
    task automatic chk_mux(input logic [2:0] own);
        logic [34:0] e;
        uart_a = 18'($urandom); uart_d = 16'($urandom); uart_we = 1'($urandom);
        m2_a   = 18'($urandom); m2_d   = 16'($urandom); m2_we   = 1'($urandom);
        m1_a   = 18'($urandom); m1_d   = 16'($urandom); m1_we   = 1'($urandom);
        vga_a  = 18'($urandom);
        #1;
        case (own)
            3'd1:    e = {uart_a, uart_d, uart_we};
            3'd2:    e = {m2_a, m2_d, m2_we};
            3'd3:    e = {m1_a, m1_d, m1_we};
            3'd4:    e = {vga_a, 16'h0, 1'b1};
            default: e = {18'h0, 16'h0, 1'b1};
        endcase
        chk("sram_mux", {SRAM_address, SRAM_write_data, SRAM_we_n}, e);
    endtask

    // One full decode from IDLE/DONE: d_uart idle UART cycles, n2/n1 counted RUN cycles.
    task automatic run_seq(input int d_uart, input int n2, input int n1, input logic spur);
        int p2, p1;
        p2 = m2p;
        p1 = m1p;
        start = 1'b1; tick; start = 1'b0;
        chk("uart_entry", {owner, uart_en, done}, {3'd1, 1'b1, 1'b0});
        for (int i = 0; i < d_uart; i++) begin
            start = spur & 1'($urandom); m2_finish = spur & 1'($urandom); m1_finish = spur & 1'($urandom);
            tick;
            chk("uart_hold", {owner, uart_en, m2_start, m1_start}, {3'd1, 1'b1, 1'b0, 1'b0});
            chk_mux(3'd1);
        end
        start = 1'b0; m2_finish = 1'b0; m1_finish = 1'b0;
        uart_done = 1'b1; tick;
        uart_done = spur & 1'($urandom);
        chk("m2_start_pulse", {owner, uart_en, m2_start, m2_cycles}, {3'd2, 1'b0, 1'b1, 32'd0});
        m2_finish = spur & 1'($urandom);
        tick;
        m2_finish = 1'b0;
        for (int i = 0; i < n2; i++) begin
            start = spur & 1'($urandom); m1_finish = spur & 1'($urandom); uart_done = spur & 1'($urandom);
            tick;
            chk("m2_run", {owner, m2_start, m1_start, done}, {3'd2, 1'b0, 1'b0, 1'b0});
            chk_mux(3'd2);
        end
        start = 1'b0; m1_finish = 1'b0; uart_done = 1'b0;
        m2_finish = 1'b1; tick; m2_finish = 1'b0;
        chk("m1_start_pulse", {owner, m1_start, m2_cycles, m1_cycles}, {3'd3, 1'b1, 32'(n2), 32'd0});
        m1_finish = spur & 1'($urandom); start = spur & 1'($urandom);
        tick;
        m1_finish = 1'b0;
        for (int i = 0; i < n1; i++) begin
            start = spur & 1'($urandom); m2_finish = spur & 1'($urandom); uart_done = spur & 1'($urandom);
            tick;
            chk("m1_run", {owner, m1_start, m2_start, done}, {3'd3, 1'b0, 1'b0, 1'b0});
            chk_mux(3'd3);
        end
        start = 1'b0; m2_finish = 1'b0; uart_done = 1'b0;
        m1_finish = 1'b1; tick; m1_finish = 1'b0;
        chk("done_state", {owner, done, uart_en, m2_cycles, m1_cycles}, {3'd4, 1'b1, 1'b0, 32'(n2), 32'(n1)});
        chk("start_pulses", {32'(m2p - p2), 32'(m1p - p1)}, {32'd1, 32'd1});
        chk_mux(3'd4);
    endtask

    vec_t tbl[16];

    initial begin
        // Walk from reset through a short sequence, including ignored inputs.
        tbl[0]  = mk(4'b1000, 3'd1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 3'd1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(4'b1010, 3'd1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(4'b0100, 3'd2, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(4'b0010, 3'd2, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(4'b0000, 3'd2, 0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(4'b1001, 3'd2, 0, 0, 0, 0, 2, 0);
        tbl[7]  = mk(4'b0010, 3'd3, 0, 0, 1, 0, 2, 0);
        tbl[8]  = mk(4'b0001, 3'd3, 0, 0, 0, 0, 2, 0);
        tbl[9]  = mk(4'b0000, 3'd3, 0, 0, 0, 0, 2, 1);
        tbl[10] = mk(4'b0001, 3'd4, 0, 0, 0, 1, 2, 1);
        tbl[11] = mk(4'b0000, 3'd4, 0, 0, 0, 1, 2, 1);
        tbl[12] = mk(4'b0110, 3'd4, 0, 0, 0, 1, 2, 1);
        tbl[13] = mk(4'b1000, 3'd1, 1, 0, 0, 0, 2, 1);
        tbl[14] = mk(4'b0100, 3'd2, 0, 1, 0, 0, 0, 1);
        tbl[15] = mk(4'b0000, 3'd2, 0, 0, 0, 0, 0, 1);

        #1;
        chk("reset_outputs", {owner, uart_en, m2_start, m1_start, done, error, m2_cycles, m1_cycles},
            {3'd0, 5'd0, 32'd0, 32'd0});
        chk_mux(3'd0);
        @(posedge clk); #1;
        Resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            {start, uart_done, m2_finish, m1_finish} = tbl[i].in;
            tick;
            chk($sformatf("table_row%0d", i),
                {owner, uart_en, m2_start, m1_start, done, m2_cycles, m1_cycles}, tbl[i].exp);
            chk_mux(tbl[i].exp.owner);
        end
        {start, uart_done, m2_finish, m1_finish} = 4'b0000;

        Resetn = 1'b0; #1;
        chk("reset_mid_m2", {owner, m2_cycles, m1_cycles, SRAM_we_n}, {3'd0, 32'd0, 32'd0, 1'b1});
        @(posedge clk); #1;
        Resetn = 1'b1;

        run_seq(10, 500, 300, 1'b0);
        chk("done_vga_port", {SRAM_address, SRAM_we_n}, {vga_a, 1'b1});

        for (int it = 0; it < 5; it++) begin
            run_seq(int'($urandom_range(0, 20)), int'($urandom_range(0, 80)),
                    int'($urandom_range(0, 80)), 1'b1);
        end

        // SKIP_M2 instance: UART goes straight to M1.
        begin
            int pb;
            pb = m2p_b;
            start_b = 1'b1; tick; start_b = 1'b0;
            chk("skip_uart", {owner_b, uart_en_b}, {3'd1, 1'b1});
            repeat (10) tick;
            uart_done_b = 1'b1; tick; uart_done_b = 1'b0;
            chk("skip_m1_start", {owner_b, m1_start_b, m2_start_b}, {3'd3, 1'b1, 1'b0});
            m2_finish_b = 1'b1;
            tick;
            repeat (5) tick;
            m2_finish_b = 1'b0;
            m1_finish_b = 1'b1; tick; m1_finish_b = 1'b0;
            chk("skip_done", {owner_b, done_b, m1_cycles_b, m2_cycles_b}, {3'd4, 1'b1, 32'd5, 32'd0});
            chk("skip_no_m2_pulse", 128'(m2p_b - pb), 128'd0);
        end

        // Reset asserted in M1_RUN while M1 is writing.
        start = 1'b1; tick; start = 1'b0;
        uart_done = 1'b1; tick; uart_done = 1'b0;
        repeat (4) tick;
        m2_finish = 1'b1; tick; m2_finish = 1'b0;
        repeat (4) tick;
        chk("pre_reset_m1_run", {owner, m1_cycles}, {3'd3, 32'd3});
        m1_we = 1'b0; #1;
        chk("pre_reset_write", 128'(SRAM_we_n), 128'd0);
        Resetn = 1'b0; #1;
        chk("async_reset", {SRAM_we_n, owner, m1_cycles, m2_cycles, done, uart_en, m1_start},
            {1'b1, 3'd0, 32'd0, 32'd0, 3'b000});
        @(posedge clk); #1;
        Resetn = 1'b1;
        tick;
        chk("idle_after_reset", {owner, uart_en}, {3'd0, 1'b0});

`ifdef MILESTONE_SEQ_WATCHDOG_EN
        start_c = 1'b1; tick; start_c = 1'b0;
        uart_done_c = 1'b1; tick; uart_done_c = 1'b0;
        chk("wd_m2_start", {owner_c, m2_start_c}, {3'd2, 1'b1});
        tick;
        repeat (99) tick;
        chk("wd_before_limit", {owner_c, error_c}, {3'd2, 1'b0});
        tick;
        chk("wd_expired", {owner_c, error_c, done_c}, {3'd0, 1'b1, 1'b0});
        start_c = 1'b1; tick; start_c = 1'b0;
        chk("wd_restart", {owner_c, error_c, uart_en_c}, {3'd1, 1'b0, 1'b1});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
